// File: rtl/config_accumulator.sv
// Per-lane tile accumulator for the packed multiplier product.
// Lanes are 1x16b, 2x8b or 4x4b, and results are handed off through a valid/ready port.
module config_accumulator #(
   parameter int LANE_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [15:0]         product,
   input  logic [1:0]          halvedPrecision,
   input  logic                in_valid,
   input  logic                in_last,
   output logic                in_ready,
   output logic [4*LANE_W-1:0] acc_out,
   output logic [3:0]          ovf_out,
   output logic [CNT_W-1:0]    beat_count,
   output logic                out_valid,
   input  logic                out_ready
);

   // state   | meaning
   // S_IDLE  | waiting for the first beat of a tile; the previous result is still visible
   // S_ACCUM | tile in progress; every accepted beat is added lane by lane
   // S_DONE  | tile complete; the result is held until out_ready
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;
   typedef enum logic [1:0] {M_FULL, M_HALF, M_QUAD} mode_t;

   localparam int ACC_W  = 4 * LANE_W;
   localparam int HALF_W = 2 * LANE_W;

   state_t            state_q, state_d;
   mode_t             mode_q, mode_d, mode_sel;
   logic [ACC_W-1:0]  acc_q, acc_d, addend, sum;
   logic [3:0]        ovf_q, ovf_d, ovf_beat;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept;

   function automatic mode_t decode_mode(input logic [1:0] hp);
      case (hp)
         2'b10:   decode_mode = M_HALF;
         2'b01:   decode_mode = M_QUAD;
         default: decode_mode = M_FULL;
      endcase
   endfunction

   assign in_ready   = (state_q != S_DONE);
   assign out_valid  = (state_q == S_DONE);
   assign accept     = in_valid && in_ready;
   assign acc_out    = acc_q;
   assign ovf_out    = ovf_q;
   assign beat_count = cnt_q;

   // The mode comes from the input only on a tile's first beat.
   assign mode_sel = (state_q == S_IDLE) ? decode_mode(halvedPrecision) : mode_q;

   always_comb begin
      addend   = '0;
      sum      = '0;
      ovf_beat = '0;
      case (mode_sel)
         M_HALF: begin
            for (int i = 0; i < 2; i++) begin
               addend[i*HALF_W +: HALF_W] = {{(HALF_W-8){product[8*i+7]}}, product[8*i +: 8]};
               sum[i*HALF_W +: HALF_W]    = acc_q[i*HALF_W +: HALF_W] + addend[i*HALF_W +: HALF_W];
               ovf_beat[i] = (acc_q[(i+1)*HALF_W-1] == addend[(i+1)*HALF_W-1]) &&
                             (sum[(i+1)*HALF_W-1] != acc_q[(i+1)*HALF_W-1]);
            end
         end
         M_QUAD: begin
            for (int i = 0; i < 4; i++) begin
               addend[i*LANE_W +: LANE_W] = {{(LANE_W-4){product[4*i+3]}}, product[4*i +: 4]};
               sum[i*LANE_W +: LANE_W]    = acc_q[i*LANE_W +: LANE_W] + addend[i*LANE_W +: LANE_W];
               ovf_beat[i] = (acc_q[(i+1)*LANE_W-1] == addend[(i+1)*LANE_W-1]) &&
                             (sum[(i+1)*LANE_W-1] != acc_q[(i+1)*LANE_W-1]);
            end
         end
         default: begin
            addend      = {{(ACC_W-16){product[15]}}, product};
            sum         = acc_q + addend;
            ovf_beat[0] = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                          (sum[ACC_W-1] != acc_q[ACC_W-1]);
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               mode_d  = mode_sel;
               acc_d   = addend;
               ovf_d   = '0;
               cnt_d   = CNT_W'(1);
               state_d = in_last ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (accept) begin
               acc_d   = sum;
               ovf_d   = ovf_q | ovf_beat;
               cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
               state_d = in_last ? S_DONE : S_ACCUM;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= M_FULL;
         acc_q   <= '0;
         ovf_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_config_accumulator.sv
// Directed bench for config_accumulator with hand-computed expected lane sums.
module tb_config_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] product;
   logic [1:0]  halvedPrecision;
   logic        in_valid, in_last, out_ready;
   logic        in_ready, out_valid;
   logic [47:0] acc_out;
   logic [3:0]  ovf_out;
   logic [15:0] beat_count;

   int total = 0;
   int bad   = 0;

   config_accumulator #(.LANE_W(12), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .product(product), .halvedPrecision(halvedPrecision),
      .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .acc_out(acc_out), .ovf_out(ovf_out), .beat_count(beat_count),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [15:0] p, input logic [1:0] m, input logic last);
      @(negedge clk);
      product = p; halvedPrecision = m; in_valid = 1'b1; in_last = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_ov", 64'(out_valid), 64'd0);
   endtask

   initial begin
      rst = 1'b1; product = '0; halvedPrecision = 2'b00;
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_ov", 64'(out_valid), 64'd0);
      chk("rst_ir", 64'(in_ready), 64'd1);
      chk("rst_acc", 64'(acc_out), 64'd0);
      @(negedge clk); rst = 1'b0;

      // Single-beat tile, then asynchronous reset while in DONE.
      beat(16'd5, 2'b00, 1'b1);
      @(negedge clk);
      chk("single_ov", 64'(out_valid), 64'd1);
      chk("single_acc", 64'(acc_out), 64'd5);
      chk("single_cnt", 64'(beat_count), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_ov", 64'(out_valid), 64'd0);
      chk("async_acc", 64'(acc_out), 64'd0);
      chk("async_ovf", 64'(ovf_out), 64'd0);
      chk("async_ir", 64'(in_ready), 64'd1);
      @(negedge clk); rst = 1'b0;

      // Two beats into a tile, then reset: they must not leak into the next tile.
      beat(16'd100, 2'b00, 1'b0);
      beat(16'd200, 2'b00, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("midtile_acc", 64'(acc_out), 64'd0);
      chk("midtile_cnt", 64'(beat_count), 64'd0);
      @(negedge clk); rst = 1'b0;

      // Mode 00: -2048 + 16129 + 2 = 14083
      beat(16'hF800, 2'b00, 1'b0);
      beat(16'h3F01, 2'b00, 1'b0);
      @(negedge clk);
      chk("m00_not_done", 64'(out_valid), 64'd0);
      beat(16'h0002, 2'b00, 1'b1);
      @(negedge clk);
      chk("m00_ov", 64'(out_valid), 64'd1);
      chk("m00_acc", 64'(acc_out), 64'h0000_0000_3703);
      chk("m00_cnt", 64'(beat_count), 64'd3);
      chk("m00_ovf", 64'(ovf_out), 64'd0);
      release_result();

      // Mode 10: hi 49-5+64=108, lo -49+12-56=-93
      beat(16'h31CF, 2'b10, 1'b0);
      beat(16'hFB0C, 2'b10, 1'b0);
      beat(16'h40C8, 2'b10, 1'b1);
      @(negedge clk);
      chk("m10_acc", 64'(acc_out), 64'h0000_6CFF_FFA3);
      chk("m10_ovf", 64'(ovf_out), 64'd0);
      chk("m10_cnt", 64'(beat_count), 64'd3);
      release_result();

      // Mode 01: three beats of four -2 lanes; mode input changes after beat 1.
      beat(16'hEEEE, 2'b01, 1'b0);
      beat(16'hEEEE, 2'b00, 1'b0);
      beat(16'hEEEE, 2'b00, 1'b1);
      @(negedge clk);
      chk("m01_acc", 64'(acc_out), 64'hFFAF_FAFF_AFFA);
      chk("m01_ovf", 64'(ovf_out), 64'd0);
      release_result();

      // Backpressure: a pending beat must wait out DONE, then be taken in IDLE.
      beat(16'd7, 2'b00, 1'b1);
      @(negedge clk);
      product = 16'd9; halvedPrecision = 2'b00; in_valid = 1'b1; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_ir", 64'(in_ready), 64'd0);
         chk("bp_acc", 64'(acc_out), 64'd7);
         chk("bp_ov", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_idle_ov", 64'(out_valid), 64'd0);
      chk("bp_idle_ir", 64'(in_ready), 64'd1);
      chk("bp_idle_acc", 64'(acc_out), 64'd7);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      chk("bp_new_ov", 64'(out_valid), 64'd1);
      chk("bp_new_acc", 64'(acc_out), 64'd9);
      chk("bp_new_cnt", 64'(beat_count), 64'd1);
      release_result();

      // Mode 01, 512 beats of lane value 4: each lane wraps to -2048 with overflow.
      for (int i = 0; i < 512; i++) beat(16'h4444, 2'b01, (i == 511));
      @(negedge clk);
      chk("wrap_acc", 64'(acc_out), 64'h8008_0080_0800);
      chk("wrap_ovf", 64'(ovf_out), 64'hF);
      chk("wrap_cnt", 64'(beat_count), 64'd512);
      release_result();

      // Overflow flags are cleared by the next tile's first beat.
      beat(16'h0001, 2'b10, 1'b1);
      @(negedge clk);
      chk("clr_ovf", 64'(ovf_out), 64'd0);
      chk("clr_acc", 64'(acc_out), 64'h0000_0000_0001);
      release_result();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
